dc_frame_loader: RTL and testbench

//  Byte-stream frame loader feeding the DC channel cores. Packs UART RX bytes into 32-bit words, parses a

---
 rtl/dc_loader_pkg.sv | 31 +++
 rtl/byte_word_packer.sv | 51 +++++
 rtl/dc_frame_loader.sv | 196 +++++++++++++++++++
 tb/tb_dc_frame_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_loader_pkg.sv
// ============================================================================
// Module      : dc_loader_pkg
// Description : Shared types and constants for the DC frame loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dc_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_TRAILER = 3'd2,
    S_COMMIT  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [7:0] c_ACK         = 8'h06;
  localparam logic [7:0] c_NAK_MAGIC   = 8'h15;
  localparam logic [7:0] c_NAK_CH      = 8'h16;
  localparam logic [7:0] c_NAK_BUSY    = 8'h17;
  localparam logic [7:0] c_NAK_CSUM    = 8'h18;
  localparam logic [7:0] c_NAK_TIMEOUT = 8'h19;

  localparam int c_HDR_MAGIC_LSB = 24;
  localparam int c_HDR_CH_LSB    = 16;
  localparam int c_HDR_AUTO_BIT  = 0;

endpackage

`default_nettype wire

// File: rtl/byte_word_packer.sv
// ============================================================================
// Module      : byte_word_packer
// Description : Packs four bytes MSB-first into a 32-bit word, one-cycle valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_flush,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  output logic        o_partial
);

  logic [1:0]  r_cnt;
  logic [23:0] r_buf;
  logic [31:0] r_word;
  logic        r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_cnt   <= 2'd0;
      r_buf   <= 24'd0;
      r_word  <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_valid) begin
        if (r_cnt == 2'd3) begin
          r_word  <= {r_buf, i_data};
          r_valid <= 1'b1;
          r_cnt   <= 2'd0;
        end else begin
          r_buf <= {r_buf[15:0], i_data};
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_word;
  assign o_partial    = (r_cnt != 2'd0);

endmodule

`default_nettype wire

// File: rtl/dc_frame_loader.sv
// ============================================================================
// Module      : dc_frame_loader
// Description : UART byte-stream frame loader with checksum, timeout and
//               shadow-to-bank commit for the DC channel register banks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dc_frame_loader
  import dc_loader_pkg::*;
#(
  parameter int         NUM_CH      = 24,
  parameter int         FRAME_WORDS = 32,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] MAGIC       = 8'hA5
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_rx_valid,
  input  logic [7:0]                        i_rx_data,
  output logic                              o_rx_ready,
  input  logic                              i_commit,
  output logic                              o_tx_valid,
  output logic [7:0]                        o_tx_data,
  input  logic                              i_tx_ready,
  output logic [NUM_CH*FRAME_WORDS*32-1:0]  o_regs,
  output logic [NUM_CH-1:0]                 o_bank_upd,
  output logic                              o_pending
);

  localparam int c_BANK_BITS = FRAME_WORDS * 32;
  localparam int c_WCNT_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int c_GAP_W     = $clog2(TIMEOUT_CYC + 2);
  localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(FRAME_WORDS - 1);
  localparam logic [c_GAP_W-1:0]  c_GAP_LIMIT = c_GAP_W'(TIMEOUT_CYC);

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_code, w_code_nxt;
  logic [7:0]            r_ch, r_ext_ch;
  logic                  r_auto, r_pending, r_ext_upd;
  logic [31:0]           r_xor;
  logic [c_WCNT_W-1:0]   r_wcnt;
  logic [c_GAP_W-1:0]    r_gap;
  logic [31:0]           r_shadow [FRAME_WORDS];
  logic [c_BANK_BITS-1:0] r_bank  [NUM_CH];
  logic [c_BANK_BITS-1:0] w_shadow_flat;

  logic        w_accept, w_word_valid, w_partial, w_flush;
  logic [31:0] w_word;
  logic        w_ext_commit, w_gap_active, w_timeout, w_bank_we;
  logic        w_hdr_accept, w_shadow_we, w_set_pending;
  logic [7:0]  w_hdr_magic, w_hdr_ch;
  logic        w_hdr_auto;

  assign o_rx_ready = ~i_rst && (r_state == S_IDLE || r_state == S_PAYLOAD || r_state == S_TRAILER);
  assign w_accept   = i_rx_valid && o_rx_ready;

  byte_word_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (w_accept),
    .i_data       (i_rx_data),
    .i_flush      (w_flush),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_partial    (w_partial)
  );

  assign w_hdr_magic  = w_word[c_HDR_MAGIC_LSB +: 8];
  assign w_hdr_ch     = w_word[c_HDR_CH_LSB +: 8];
  assign w_hdr_auto   = w_word[c_HDR_AUTO_BIT];
  assign w_ext_commit = i_commit && r_pending && (r_state != S_COMMIT);
  assign w_gap_active = (r_state == S_PAYLOAD) || (r_state == S_TRAILER) ||
                        ((r_state == S_IDLE) && w_partial);
  assign w_timeout    = w_gap_active && (r_gap > c_GAP_LIMIT);
  assign w_bank_we    = (r_state == S_COMMIT) || w_ext_commit;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_hdr_accept  = 1'b0;
    w_shadow_we   = 1'b0;
    w_set_pending = 1'b0;
    w_flush       = 1'b0;
    case (r_state)
      S_IDLE, S_PAYLOAD, S_TRAILER: begin
        if (w_timeout) begin
          w_flush     = 1'b1;
          w_code_nxt  = c_NAK_TIMEOUT;
          w_state_nxt = S_RESP;
        end else if (w_word_valid) begin
          if (r_state == S_IDLE) begin
            if (w_hdr_magic != MAGIC) begin
              w_code_nxt  = c_NAK_MAGIC;
              w_state_nxt = S_RESP;
            end else if ({1'b0, w_hdr_ch} >= 9'(NUM_CH)) begin
              w_code_nxt  = c_NAK_CH;
              w_state_nxt = S_RESP;
            // A commit landing on the same cycle frees the shadow first
            end else if (r_pending && !w_ext_commit) begin
              w_code_nxt  = c_NAK_BUSY;
              w_state_nxt = S_RESP;
            end else begin
              w_hdr_accept = 1'b1;
              w_state_nxt  = S_PAYLOAD;
            end
          end else if (r_state == S_PAYLOAD) begin
            w_shadow_we = 1'b1;
            if (r_wcnt == c_LAST_WORD) w_state_nxt = S_TRAILER;
          end else begin
            if (w_word != r_xor) begin
              w_code_nxt  = c_NAK_CSUM;
              w_state_nxt = S_RESP;
            end else if (r_auto) begin
              w_state_nxt = S_COMMIT;
            end else begin
              w_set_pending = 1'b1;
              w_code_nxt    = c_ACK;
              w_state_nxt   = S_RESP;
            end
          end
        end
      end
      S_COMMIT: begin
        w_code_nxt  = c_ACK;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (i_tx_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code    <= 8'd0;
      r_ch      <= 8'd0;
      r_ext_ch  <= 8'd0;
      r_auto    <= 1'b0;
      r_pending <= 1'b0;
      r_ext_upd <= 1'b0;
      r_xor     <= 32'd0;
      r_wcnt    <= '0;
      r_gap     <= '0;
    end else begin
      r_code    <= w_code_nxt;
      r_ext_upd <= w_ext_commit;
      if (w_ext_commit) r_ext_ch <= r_ch;
      if (w_accept || !w_gap_active) r_gap <= '0;
      else                           r_gap <= r_gap + 1'b1;
      if (w_hdr_accept) begin
        r_ch   <= w_hdr_ch;
        r_auto <= w_hdr_auto;
        r_xor  <= w_word;
        r_wcnt <= '0;
      end else if (w_shadow_we) begin
        r_xor  <= r_xor ^ w_word;
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_set_pending)                              r_pending <= 1'b1;
      else if (w_ext_commit || r_state == S_COMMIT)   r_pending <= 1'b0;
    end
  end

  for (genvar w = 0; w < FRAME_WORDS; w++) begin : g_shadow
    always_ff @(posedge i_clk) begin
      if (i_rst)                                         r_shadow[w] <= 32'd0;
      else if (w_shadow_we && r_wcnt == c_WCNT_W'(w))    r_shadow[w] <= w_word;
    end
    assign w_shadow_flat[w*32 +: 32] = r_shadow[w];
  end

  // Each bank is replaced in a single edge so consumers never see a mix
  for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
    always_ff @(posedge i_clk) begin
      if (i_rst)                               r_bank[c] <= '0;
      else if (w_bank_we && r_ch == 8'(c))     r_bank[c] <= w_shadow_flat;
    end
    assign o_regs[c*c_BANK_BITS +: c_BANK_BITS] = r_bank[c];
    assign o_bank_upd[c] = ((r_state == S_COMMIT) && (r_ch == 8'(c))) ||
                           (r_ext_upd && (r_ext_ch == 8'(c)));
  end

  assign o_tx_valid = (r_state == S_RESP);
  assign o_tx_data  = r_code;
  assign o_pending  = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_dc_frame_loader.sv
// ============================================================================
// Module      : tb_dc_frame_loader
// Description : Self-checking bench for dc_frame_loader against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dc_frame_loader;

  localparam int         NUM_CH = 4;
  localparam int         FW     = 4;
  localparam int         TMO    = 40;
  localparam logic [7:0] MAGIC  = 8'hA5;
  localparam int         RW     = NUM_CH * FW * 32;

  logic i_clk = 1'b0;
  logic i_rst, i_rx_valid, i_commit, i_tx_ready;
  logic [7:0] i_rx_data;
  logic o_rx_ready, o_tx_valid, o_pending;
  logic [7:0] o_tx_data;
  logic [RW-1:0] o_regs;
  logic [NUM_CH-1:0] o_bank_upd;

  dc_frame_loader #(.NUM_CH(NUM_CH), .FRAME_WORDS(FW), .TIMEOUT_CYC(TMO), .MAGIC(MAGIC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rx_ready(o_rx_ready), .i_commit(i_commit), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready), .o_regs(o_regs),
    .o_bank_upd(o_bank_upd), .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: committed banks, staged frame and pending flag
  logic [31:0] m_bank [NUM_CH][FW];
  logic [31:0] m_shadow [FW];
  bit          m_pending;
  int          m_pend_ch;

  function automatic logic [RW-1:0] model_regs();
    logic [RW-1:0] v;
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < FW; w++)
        v[(c*FW+w)*32 +: 32] = m_bank[c][w];
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < FW; w++) m_bank[c][w] = 32'd0;
    for (int w = 0; w < FW; w++) m_shadow[w] = 32'd0;
    m_pending = 0;
    m_pend_ch = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (!o_rx_ready && n < 200) begin @(negedge i_clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_byte: o_rx_ready=%0b after %0d cycles, required 1", o_rx_ready, n);
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'd0; i_commit = 1'b0; i_tx_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_tx_valid, o_tx_data, o_bank_upd, o_pending, o_rx_ready} !== '0 || o_regs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tx_v=%0b tx_d=%h upd=%b pend=%0b rdy=%0b regs_nz=%0b, required all 0",
               o_tx_valid, o_tx_data, o_bank_upd, o_pending, o_rx_ready, |o_regs);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_rx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_rx_ready: got %0b required 1", o_rx_ready);
    end
  endtask

  // Sends one frame (header only if the model rejects the header) and checks the reply
  task automatic do_frame(input logic [7:0] magic, input int ch, input bit auto_c,
                          input bit bad_csum, input bit commit_hdr, input string name);
    logic [31:0] hdr, x;
    logic [31:0] pl [FW];
    logic [7:0]  exp_code, got_code;
    logic [NUM_CH-1:0] exp_upd, got_upd, exp_hupd;
    bit hdr_ok, good, seen_tx, seen_upd;
    int k, tx_k, upd_k;
    hdr = {magic, 8'(ch), 15'($urandom), auto_c};
    send_word(hdr);
    if (commit_hdr) begin
      exp_hupd = '0;
      if (m_pending) exp_hupd[m_pend_ch] = 1'b1;
      i_commit = 1'b1;
      @(negedge i_clk);
      i_commit = 1'b0;
      checks++;
      if (o_bank_upd !== exp_hupd) begin
        errors++; $display("FAIL %s_commit_upd: got %b required %b", name, o_bank_upd, exp_hupd);
      end
      if (m_pending) begin
        for (int w = 0; w < FW; w++) m_bank[m_pend_ch][w] = m_shadow[w];
        m_pending = 0;
      end
    end
    hdr_ok = 0; good = 0; exp_upd = '0;
    if (magic != MAGIC)    exp_code = 8'h15;
    else if (ch >= NUM_CH) exp_code = 8'h16;
    else if (m_pending)    exp_code = 8'h17;
    else begin hdr_ok = 1; exp_code = 8'h00; end
    if (hdr_ok) begin
      x = hdr;
      for (int w = 0; w < FW; w++) begin
        pl[w] = $urandom;
        x ^= pl[w];
        send_word(pl[w]);
      end
      send_word(x ^ {31'd0, bad_csum});
      if (bad_csum) exp_code = 8'h18;
      else begin
        good = 1;
        exp_code = 8'h06;
        if (auto_c) begin
          for (int w = 0; w < FW; w++) m_bank[ch][w] = pl[w];
          exp_upd[ch] = 1'b1;
        end else begin
          for (int w = 0; w < FW; w++) m_shadow[w] = pl[w];
          m_pending = 1; m_pend_ch = ch;
        end
      end
    end
    k = 1; tx_k = 0; upd_k = 0; seen_tx = 0; seen_upd = 0; got_upd = '0; got_code = 8'h00;
    while (!seen_tx && k < 60) begin
      if (o_bank_upd != '0 && !seen_upd) begin seen_upd = 1; upd_k = k; got_upd = o_bank_upd; end
      if (o_tx_valid) begin seen_tx = 1; tx_k = k; got_code = o_tx_data; end
      else begin @(negedge i_clk); k++; end
    end
    @(negedge i_clk);
    checks++;
    if (!seen_tx || got_code !== exp_code) begin
      errors++; $display("FAIL %s_code: got %h (seen=%0b) required %h", name, got_code, seen_tx, exp_code);
    end
    checks++;
    if (got_upd !== exp_upd) begin
      errors++; $display("FAIL %s_upd: got %b required %b", name, got_upd, exp_upd);
    end
    if (good) begin
      checks++;
      if (auto_c && (upd_k != 2 || tx_k != 3)) begin
        errors++; $display("FAIL %s_latency: upd=%0d tx=%0d required 2/3", name, upd_k, tx_k);
      end else if (!auto_c && tx_k != 2) begin
        errors++; $display("FAIL %s_latency: tx=%0d required 2", name, tx_k);
      end
    end
    checks++;
    if (o_pending !== m_pending) begin
      errors++; $display("FAIL %s_pending: got %0b required %0b", name, o_pending, m_pending);
    end
    checks++;
    if (o_regs !== model_regs()) begin
      errors++; $display("FAIL %s_regs: got %h required %h", name, o_regs, model_regs());
    end
  endtask

  task automatic test_commit(input string name);
    logic [NUM_CH-1:0] exp_upd;
    exp_upd = '0;
    if (m_pending) exp_upd[m_pend_ch] = 1'b1;
    i_commit = 1'b1;
    @(negedge i_clk);
    i_commit = 1'b0;
    if (m_pending) begin
      for (int w = 0; w < FW; w++) m_bank[m_pend_ch][w] = m_shadow[w];
      m_pending = 0;
    end
    checks++;
    if (o_bank_upd !== exp_upd) begin
      errors++; $display("FAIL %s_upd: got %b required %b", name, o_bank_upd, exp_upd);
    end
    checks++;
    if (o_regs !== model_regs() || o_pending !== 1'b0) begin
      errors++; $display("FAIL %s_state: pend=%0b regs=%h required 0 / %h", name, o_pending, o_regs, model_regs());
    end
    repeat (4) begin
      @(negedge i_clk);
      checks++;
      if (o_tx_valid !== 1'b0 || o_bank_upd !== '0) begin
        errors++; $display("FAIL %s_quiet: tx_v=%0b upd=%b required 0", name, o_tx_valid, o_bank_upd);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    send_word({MAGIC, 8'd2, 15'd0, 1'b1});
    send_word($urandom);
    send_word($urandom);
    repeat (TMO - 2) @(negedge i_clk);
    checks++;
    if (o_tx_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_early: tx_v=%0b required 0", o_tx_valid);
    end
    while (!o_tx_valid && n < 30) begin @(negedge i_clk); n++; end
    checks++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h19) begin
      errors++; $display("FAIL timeout_code: tx_v=%0b got %h required 19", o_tx_valid, o_tx_data);
    end
    @(negedge i_clk);
    checks++;
    if (o_regs !== model_regs() || o_pending !== 1'b0) begin
      errors++; $display("FAIL timeout_state: pend=%0b regs=%h required 0 / %h", o_pending, o_regs, model_regs());
    end
    do_frame(MAGIC, 2, 1'b1, 1'b0, 1'b0, "after_timeout");
  endtask

  task automatic test_tx_stall();
    int n = 0;
    bit ok = 1;
    i_tx_ready = 1'b0;
    send_word({8'h00, 8'd1, 16'd0});
    while (!o_tx_valid && n < 30) begin @(negedge i_clk); n++; end
    repeat (50) begin
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h15 || o_rx_ready !== 1'b0) ok = 0;
      @(negedge i_clk);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL tx_stall_hold: tx_v=%0b data=%h rdy=%0b required 1/15/0", o_tx_valid, o_tx_data, o_rx_ready);
    end
    i_tx_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_tx_valid !== 1'b0 || o_rx_ready !== 1'b1) begin
      errors++; $display("FAIL tx_stall_release: tx_v=%0b rdy=%0b required 0/1", o_tx_valid, o_rx_ready);
    end
  endtask

  task automatic test_reset_mid();
    send_word({MAGIC, 8'd1, 15'd0, 1'b1});
    send_word($urandom);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    model_clear();
    checks++;
    if ({o_tx_valid, o_tx_data, o_bank_upd, o_pending} !== '0 || o_regs !== '0) begin
      errors++; $display("FAIL reset_mid: tx_v=%0b tx_d=%h upd=%b pend=%0b regs_nz=%0b required all 0",
                         o_tx_valid, o_tx_data, o_bank_upd, o_pending, |o_regs);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_rx_ready !== 1'b1 || o_tx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_release: rdy=%0b tx_v=%0b required 1/0", o_rx_ready, o_tx_valid);
    end
    do_frame(MAGIC, 3, 1'b1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int ch;
    bit auto_c;
    logic [7:0] mg;
    for (int i = 0; i < 8; i++) begin
      ch     = $urandom_range(0, NUM_CH);
      auto_c = 1'($urandom_range(0, 1));
      mg     = ($urandom_range(0, 7) == 0) ? 8'h5A : MAGIC;
      do_frame(mg, ch, auto_c, 1'($urandom_range(0, 5) == 0), 1'b0, "random");
      if (m_pending && $urandom_range(0, 1) == 1) test_commit("random_commit");
    end
  endtask

  initial begin
    test_reset();
    do_frame(MAGIC, 3, 1'b1, 1'b0, 1'b0, "auto_ch3");
    do_frame(MAGIC, 0, 1'b0, 1'b0, 1'b0, "pending_ch0");
    test_commit("commit_ch0");
    test_commit("commit_idle");
    do_frame(MAGIC, 1, 1'b1, 1'b1, 1'b0, "bad_csum");
    do_frame(MAGIC, NUM_CH, 1'b1, 1'b0, 1'b0, "bad_ch");
    do_frame(8'h00, 1, 1'b1, 1'b0, 1'b0, "bad_magic");
    do_frame(MAGIC, 1, 1'b0, 1'b0, 1'b0, "pending_ch1");
    do_frame(MAGIC, 2, 1'b1, 1'b0, 1'b0, "busy");
    do_frame(MAGIC, 2, 1'b1, 1'b0, 1'b1, "commit_with_header");
    test_timeout();
    test_tx_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
